// File: rtl/sum_avg_pkg.sv
// Shared types and constants for the block averager and its optional max tracker.
package sum_avg_pkg;

  localparam int unsigned LOG2_N_MAX = 6;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/sum_block_max.sv
// Running maximum of the samples accepted in the current block; clear has priority over en.
module sum_block_max
  import sum_avg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] max
);

  logic [DATA_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (clear) begin
      max_d = '0;
    end else if (en && (din > max_q)) begin
      max_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max = max_q;

endmodule

// File: rtl/sum_block_avg.sv
// Averages blocks of 2^LOG2_N unsigned samples and holds each result until handshaked.
// Define SUM_BLOCK_AVG_MAX_EN to also report the per-block maximum on out_max.
module sum_block_avg
  import sum_avg_pkg::*;
#(
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        count
);

  localparam int unsigned ACC_W    = DATA_W + LOG2_N;
  localparam logic [5:0]  LAST_IDX = 6'((1 << LOG2_N) - 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [5:0]        count_q, count_d;
  logic [DATA_W-1:0] out_avg_q, out_avg_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  sum;
  logic              abort, accept, done;

  assign abort  = (state_q == ACCUM) && clr;
  assign accept = (state_q == ACCUM) && !clr && in_valid;
  assign done   = accept && (count_q == LAST_IDX);
  assign sum    = acc_q + ACC_W'(in_data);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_avg_d   = out_avg_q;
    out_valid_d = out_valid_q;
    in_ready    = (state_q == ACCUM);
    case (state_q)
      ACCUM: begin
        if (abort) begin
          acc_d   = '0;
          count_d = '0;
        end else if (done) begin
          acc_d       = '0;
          count_d     = '0;
          out_avg_d   = DATA_W'(sum >> LOG2_N);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d   = sum;
          count_d = count_q + 6'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_avg_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_avg_q   <= out_avg_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SUM_BLOCK_AVG_MAX_EN
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] out_max_q, out_max_d;

  sum_block_max u_max (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (abort || done),
    .en    (accept),
    .din   (in_data),
    .max   (run_max)
  );

  // The completing sample is not yet in run_max, so fold it in here.
  always_comb begin
    out_max_d = out_max_q;
    if (done) begin
      out_max_d = (in_data > run_max) ? in_data : run_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_max_q <= '0;
    end else begin
      out_max_q <= out_max_d;
    end
  end

  assign out_max = out_max_q;
`else
  assign out_max = '0;
`endif

  assign out_avg   = out_avg_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sum_block_avg.sv
// Randomised and directed checks of sum_block_avg (LOG2_N=3) against a queue-based block model.
module tb_sum_block_avg;

  localparam int unsigned LOG2_N = 3;
  localparam int unsigned NBLK   = 1 << LOG2_N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic [7:0] out_avg;
  logic [7:0] out_max;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: samples of the open block, plus the last registered result.
  int unsigned blk[$];
  bit          pending = 1'b0;
  int unsigned exp_avg = 0;
  int unsigned exp_max = 0;

  sum_block_avg #(.LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_avg   (out_avg),
    .out_max   (out_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned s, m;
    if (!rst_n) begin
      blk.delete();
      pending = 1'b0;
      exp_avg = 0;
      exp_max = 0;
    end else if (pending) begin
      if (out_ready) pending = 1'b0;
    end else if (clr) begin
      blk.delete();
    end else if (in_valid) begin
      blk.push_back(int'(in_data));
      if (blk.size() == NBLK) begin
        s = 0;
        m = 0;
        foreach (blk[i]) begin
          s += blk[i];
          if (blk[i] > m) m = blk[i];
        end
        exp_avg = s / NBLK;
`ifdef SUM_BLOCK_AVG_MAX_EN
        exp_max = m;
`else
        exp_max = 0;
`endif
        pending = 1'b1;
        blk.delete();
      end
    end
  endtask

  // Inputs must be set before calling; checks run on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("in_ready",  in_ready,  pending ? 0 : 1);
    check_val("out_valid", out_valid, pending ? 1 : 0);
    check_val("count",     count,     blk.size());
    check_val("out_avg",   out_avg,   exp_avg);
    check_val("out_max",   out_max,   exp_max);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy,
                       input logic c, input logic rn);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clr       = c;
    rst_n     = rn;
    cycle();
  endtask

  initial begin
    in_valid = 0; in_data = '0; out_ready = 0; clr = 0; rst_n = 0;
    cycle();
    cycle();

    // Samples 1..8 back-to-back, out_ready high: avg 4, max 8, one-cycle valid.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'd99, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);

    // Full-scale samples must not overflow the accumulator.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held five cycles with in_valid high.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(3 * i + 5), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'd200, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd200, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd7, 1'b1, 1'b0, 1'b1);

    // clr mid-block discards earlier samples and the same-cycle sample.
    drive(1'b1, 8'd250, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);

    // Reset while holding a result drops it.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(20 + i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 1) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 199) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
